// File: rtl/hc_pkg.sv
// Shared definitions for the hc194 universal shift register:
// mode select constants, the mode enum and the width limit.
package hc_pkg;

    localparam logic [1:0] HC194_HOLD = 2'b00;
    localparam logic [1:0] HC194_SHR  = 2'b01;
    localparam logic [1:0] HC194_SHL  = 2'b10;
    localparam logic [1:0] HC194_LOAD = 2'b11;

    localparam int HC194_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        MODE_HOLD = HC194_HOLD,
        MODE_SHR  = HC194_SHR,
        MODE_SHL  = HC194_SHL,
        MODE_LOAD = HC194_LOAD
    } hc194_mode_t;

endpackage

// File: rtl/hc_sync2.sv
// Single-bit two-flop synchroniser, cleared by the asynchronous
// active-low clear RD. Used on the serial inputs of hc194_shift
// when HC194_SERIAL_SYNC_EN is defined.
module hc_sync2 (
    input  logic Clk,
    input  logic RD,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Two-stage capture; both stages clear so post-reset shifts insert 0s.
    always_ff @(posedge Clk or negedge RD) begin
        if (!RD) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/hc194_shift.sv
// hc194_shift: parameterised universal bidirectional shift register with
// 74HC194 semantics (hold, shift right, shift left, parallel load).
// "Right" moves data from Q[0] toward Q[WIDTH-1].
// Optional macro HC194_SERIAL_SYNC_EN inserts a two-flop synchroniser on
// DSR and DSL (serial latency 3 edges, load latency stays 1).
module hc194_shift
    import hc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             RD,
    input  logic [1:0]       S,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic             SOR,
    output logic             SOL
);

    if (WIDTH < 2 || WIDTH > HC194_WIDTH_MAX) begin : g_width_check
        $error("hc194_shift: WIDTH must be in 2..%0d", HC194_WIDTH_MAX);
    end

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
    logic             dsr_int;
    logic             dsl_int;
    hc194_mode_t      mode;

`ifdef HC194_SERIAL_SYNC_EN
    hc_sync2 u_sync_dsr (
        .Clk (Clk),
        .RD  (RD),
        .d   (DSR),
        .q   (dsr_int)
    );

    hc_sync2 u_sync_dsl (
        .Clk (Clk),
        .RD  (RD),
        .d   (DSL),
        .q   (dsl_int)
    );
`else
    assign dsr_int = DSR;
    assign dsl_int = DSL;
`endif

    // Per-bit shift sources; the end bits take the serial inputs and the
    // bit shifted out of the far end is simply dropped (no wrap-around).
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == 0) begin : g_shr_end
            assign shr_vec[gi] = dsr_int;
        end else begin : g_shr_mid
            assign shr_vec[gi] = q_reg[gi-1];
        end

        if (gi == WIDTH - 1) begin : g_shl_end
            assign shl_vec[gi] = dsl_int;
        end else begin : g_shl_mid
            assign shl_vec[gi] = q_reg[gi+1];
        end
    end

    assign mode = hc194_mode_t'(S);

    // Mode mux; anything unrecognised (X/Z in simulation) holds.
    always_comb begin
        q_next = q_reg;
        case (mode)
            MODE_HOLD: q_next = q_reg;
            MODE_SHR:  q_next = shr_vec;
            MODE_SHL:  q_next = shl_vec;
            MODE_LOAD: q_next = P;
            default:   q_next = q_reg;
        endcase
    end

    // Main register; RD clears immediately and overrides any clock edge.
    always_ff @(posedge Clk or negedge RD) begin
        if (!RD) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign Q   = q_reg;
    assign SOR = q_reg[WIDTH-1];
    assign SOL = q_reg[0];

    // Mode select must be a known value whenever the register is active.
    a_mode_known: assert property (@(posedge Clk) disable iff (!RD) !$isunknown(S))
        else $error("hc194_shift: unknown value on S");

endmodule

// File: tb/tb_hc194_shift.sv
// Testbench for hc194_shift: two cascaded WIDTH=4 instances (SOR0 -> DSR1).
// A driver issues directed then random cycles and pushes the expected
// post-edge state, computed by an integer-arithmetic model, into a queue;
// a monitor pops and compares after every rising edge.
module tb_hc194_shift;

    localparam int W = 4;
    localparam logic [W-1:0] MASK = {W{1'b1}};
`ifdef HC194_SERIAL_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         RD  = 1'b0;
    logic [1:0]   S   = 2'b00;
    logic         dsr0 = 1'b0;
    logic         dsl0 = 1'b0;
    logic         dsl1 = 1'b0;
    logic [W-1:0] p0 = '0;
    logic [W-1:0] p1 = '0;
    logic [W-1:0] q0, q1;
    logic         sor0, sol0, sor1, sol1;

    typedef struct {
        logic [W-1:0] q0;
        logic [W-1:0] q1;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: register contents and serial-input history
    int   m0 = 0, m1 = 0;
    int   h_dsr0[2], h_dsl0[2], h_dsr1[2], h_dsl1[2];

    hc194_shift #(.WIDTH(W)) u_dut0 (
        .Clk (Clk), .RD (RD), .S (S), .DSR (dsr0), .DSL (dsl0),
        .P (p0), .Q (q0), .SOR (sor0), .SOL (sol0)
    );

    hc194_shift #(.WIDTH(W)) u_dut1 (
        .Clk (Clk), .RD (RD), .S (S), .DSR (sor0), .DSL (dsl1),
        .P (p1), .Q (q1), .SOR (sor1), .SOL (sol1)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%b required=%b", name, act, req);
    endtask

    function automatic int apply(input int q, input logic [1:0] s, input int dr, input int dl, input int p);
        case (s)
            2'd0:    return q;
            2'd1:    return ((q * 2) + dr) % (1 << W);
            2'd2:    return (q / 2) + dl * (1 << (W - 1));
            default: return p;
        endcase
    endfunction

    // Effective serial value seen by the shift path, then advance history.
    function automatic int serial_eff(inout int h[2], input int din);
        int e;
        if (!SYNC) return din;
        e    = h[1];
        h[1] = h[0];
        h[0] = din;
        return e;
    endfunction

    task automatic model_clear();
        m0 = 0; m1 = 0;
        for (int i = 0; i < 2; i++) begin
            h_dsr0[i] = 0; h_dsl0[i] = 0; h_dsr1[i] = 0; h_dsl1[i] = 0;
        end
    endtask

    // One clock cycle: drive at the falling edge, predict the next rising edge.
    task automatic cycle(input string tag, input logic rd, input logic [1:0] s,
                         input logic dr0, input logic dl0, input logic dl1,
                         input logic [W-1:0] pp0, input logic [W-1:0] pp1);
        exp_t e;
        int   e_dr0, e_dl0, e_dr1, e_dl1, top0;
        @(negedge Clk);
        RD = rd; S = s; dsr0 = dr0; dsl0 = dl0; dsl1 = dl1; p0 = pp0; p1 = pp1;
        if (!rd) begin
            model_clear();
            #1;
            check({tag, "_async_clr_q0"}, q0, '0);
            check({tag, "_async_clr_q1"}, q1, '0);
        end else begin
            top0  = (m0 >> (W - 1)) & 1;
            e_dr0 = serial_eff(h_dsr0, int'(dr0));
            e_dl0 = serial_eff(h_dsl0, int'(dl0));
            e_dr1 = serial_eff(h_dsr1, top0);
            e_dl1 = serial_eff(h_dsl1, int'(dl1));
            m0 = apply(m0, s, e_dr0, e_dl0, int'(pp0));
            m1 = apply(m1, s, e_dr1, e_dl1, int'(pp1));
        end
        e.q0  = W'(m0);
        e.q1  = W'(m1);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every post-edge state against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, "_q0"}, q0, e.q0);
                check({e.tag, "_q1"}, q1, e.q1);
                check({e.tag, "_sor0"}, {{(W-1){1'b0}}, sor0}, {{(W-1){1'b0}}, e.q0[W-1]});
                check({e.tag, "_sol0"}, {{(W-1){1'b0}}, sol0}, {{(W-1){1'b0}}, e.q0[0]});
            end
        end
    end

    initial begin
        logic [7:0] pat;
        int         wait_cnt;
        pat = 8'b1000_0001;
        model_clear();

        // Reset, then preload 1010 and clear it asynchronously with S=11,P=1111 ignored
        cycle("rst0",   1'b0, 2'b00, 0, 0, 0, 4'h0, 4'h0);
        cycle("pre",    1'b1, 2'b11, 0, 0, 0, 4'b1010, 4'b0110);
        cycle("rstld",  1'b0, 2'b11, 0, 0, 0, 4'b1111, 4'b1111);

        // Load and hold
        cycle("load",   1'b1, 2'b11, 0, 0, 0, 4'b1011, 4'b0101);
        for (int i = 0; i < 5; i++) cycle("hold", 1'b1, 2'b00, 1, 1, 1, 4'hF, 4'hF);

        // Shift right from zero: DSR 1,0,1,1 then 0
        cycle("rst1",   1'b0, 2'b00, 0, 0, 0, 4'h0, 4'h0);
        cycle("shr_a",  1'b1, 2'b01, 1, 0, 0, 4'h0, 4'h0);
        cycle("shr_b",  1'b1, 2'b01, 0, 0, 0, 4'h0, 4'h0);
        cycle("shr_c",  1'b1, 2'b01, 1, 0, 0, 4'h0, 4'h0);
        cycle("shr_d",  1'b1, 2'b01, 1, 0, 0, 4'h0, 4'h0);
        cycle("shr_e",  1'b1, 2'b01, 0, 0, 0, 4'h0, 4'h0);

        // Shift left from 1011 with DSL=0
        cycle("ldl",    1'b1, 2'b11, 0, 0, 0, 4'b1011, 4'b1100);
        for (int i = 0; i < 4; i++) cycle("shl", 1'b1, 2'b10, 0, 0, 0, 4'h0, 4'h0);

        // Cascade: 8-bit pattern through both stages, RD pulse at edge 5, restart
        cycle("rst2",   1'b0, 2'b00, 0, 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) cycle("casc_a", 1'b1, 2'b01, pat[7-i], 0, 0, 4'h0, 4'h0);
        cycle("casc_rd", 1'b0, 2'b01, pat[3], 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 8 + (SYNC ? 2 : 0); i++)
            cycle("casc_b", 1'b1, 2'b01, (i < 8) ? pat[7-i] : 1'b0, 0, 0, 4'h0, 4'h0);

        // Serial single-bit pulse after a fresh reset (latency depends on build)
        cycle("rst3",   1'b0, 2'b00, 0, 0, 0, 4'h0, 4'h0);
        cycle("pulse",  1'b1, 2'b01, 1, 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) cycle("pulse_t", 1'b1, 2'b01, 0, 0, 0, 4'h0, 4'h0);
        cycle("ld1",    1'b1, 2'b11, 0, 0, 0, 4'b0110, 4'b1001);

        // Randomised traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            logic rd;
            rd = ($urandom_range(0, 39) != 0);
            cycle("rand", rd, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), W'($urandom), W'($urandom));
        end
        cycle("last", 1'b1, 2'b00, 0, 0, 0, 4'h0, 4'h0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge Clk);
            wait_cnt++;
        end
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: actual=%0d pending required=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
